// File: rtl/led_pkg.sv
// led_pkg: shared state encoding, frame sizing and WS2812B timing for the LED string datapath
package led_pkg;

    typedef enum logic [2:0] {INIT, WAIT_FRAME, FETCH, LOAD, DRAIN, LATCH} state_t;

    function automatic int frame_bytes(input int n_strings, input int n_leds);
        return 3 * n_strings * n_leds;
    endfunction

    localparam int BITS_PER_PIXEL = 24;
    localparam int T0H_NS         = 400;
    localparam int T0L_NS         = 850;
    localparam int T1H_NS         = 800;
    localparam int T1L_NS         = 450;
    localparam int TRESET_NS      = 50000;

endpackage

// File: rtl/led_frame_sequencer_if.sv
// led_frame_sequencer_if: pixel FIFO read port and serializer load bus of the frame sequencer
interface led_frame_sequencer_if #(
    parameter int N_STRINGS = 5,
    parameter int LEVEL_W   = 12
);
    logic [LEVEL_W-1:0]   fifo_level;
    logic                 fifo_rd_en;
    logic [7:0]           fifo_rd_data;
    logic [23:0]          pix_data;
    logic [N_STRINGS-1:0] pix_wr;
    logic [N_STRINGS-1:0] ser_busy;

    modport master (
        output fifo_rd_en, pix_data, pix_wr,
        input  fifo_level, fifo_rd_data, ser_busy
    );

    modport slave (
        input  fifo_rd_en, pix_data, pix_wr,
        output fifo_level, fifo_rd_data, ser_busy
    );
endinterface

// File: rtl/led_pixel_assembler.sv
// led_pixel_assembler: shifts three FIFO bytes into a 24-bit pixel, byte 0 ending in bits [7:0]
module led_pixel_assembler #(
    parameter logic [7:0] INIT_BYTE = 8'h08
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic [7:0]  data,
    input  logic        preset,
    input  logic        consume,
    output logic [23:0] pixel,
    output logic        ready,
    output logic        last
);
    logic       vld;
    logic [1:0] cnt;

    // last is high while the third byte of a pixel sits on the data bus
    assign last = vld && cnt == 2'd2;

    // FIFO data trails the pop by one cycle, so capture follows a delayed copy of rd
    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= 1'b0;
            cnt   <= 2'd0;
            pixel <= '0;
            ready <= 1'b0;
        end else begin
            vld   <= rd;
            ready <= preset || ((ready || last) && !consume);
            if (preset) begin
                pixel <= {3{INIT_BYTE}};
                cnt   <= 2'd0;
            end else if (vld) begin
                pixel <= {data, pixel[23:8]};
                cnt   <= last ? 2'd0 : cnt + 2'd1;
            end
        end
    end
endmodule

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: fetches buffered frames, loads per-string serializers, enforces latch gaps (LED_INIT_FRAME_EN adds the power-up init frame)
module led_frame_sequencer
    import led_pkg::*;
#(
    parameter int         N_STRINGS         = 5,
    parameter int         N_LEDS_PER_STRING = 4,
    parameter int         LATCH_CYCLES      = 6000,
    parameter logic [7:0] INIT_BYTE         = 8'h08,
    parameter int         LEVEL_W           = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  hblank_req,
    led_frame_sequencer_if.master bus,
    output logic                  frame_done,
    output logic                  busy
);
    localparam int FRAME_BYTES = frame_bytes(N_STRINGS, N_LEDS_PER_STRING);
    localparam int SW = N_STRINGS > 1 ? $clog2(N_STRINGS) : 1;
    localparam int PW = N_LEDS_PER_STRING > 1 ? $clog2(N_LEDS_PER_STRING) : 1;
    localparam int LW = LATCH_CYCLES > 1 ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [LEVEL_W-1:0] FRAME_LVL  = LEVEL_W'(FRAME_BYTES);
    localparam logic [LW-1:0]      LATCH_LOAD = LW'(LATCH_CYCLES - 1);
    localparam logic [SW-1:0]      LAST_S     = SW'(N_STRINGS - 1);
    localparam logic [PW-1:0]      LAST_P     = PW'(N_LEDS_PER_STRING - 1);

`ifdef LED_INIT_FRAME_EN
    localparam state_t RST_STATE = INIT;
    localparam logic   RST_INIT  = 1'b1;
`else
    localparam state_t RST_STATE = LATCH;
    localparam logic   RST_INIT  = 1'b0;
`endif

    state_t               state;
    logic [SW-1:0]        s;
    logic [PW-1:0]        p;
    logic [LW-1:0]        lcnt;
    logic [1:0]           rcnt;
    logic                 pend;
    logic                 fr;
    logic                 init_run;
    logic                 rd_en;
    logic [N_STRINGS-1:0] wr;
    logic                 preset;
    logic                 ready;
    logic                 last;
    logic                 fire;

    assign bus.fifo_rd_en = rd_en;
    assign bus.pix_wr     = wr;
    assign preset         = state == INIT;
    assign fire = state == LOAD && (ready || last) && !bus.ser_busy[s] && !wr[s];

    led_pixel_assembler #(.INIT_BYTE(INIT_BYTE)) u_asm (
        .clk     (clk),
        .rst     (rst),
        .rd      (rd_en),
        .data    (bus.fifo_rd_data),
        .preset  (preset),
        .consume (fire),
        .pixel   (bus.pix_data),
        .ready   (ready),
        .last    (last)
    );

    // frame FSM; fr marks that the running latch gap closes a frame and owes a frame_done
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RST_STATE;
            init_run   <= RST_INIT;
            fr         <= 1'b1;
            lcnt       <= LATCH_LOAD;
            s          <= '0;
            p          <= '0;
            rcnt       <= 2'd0;
            pend       <= 1'b0;
            rd_en      <= 1'b0;
            wr         <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b1;
        end else begin
            wr         <= '0;
            frame_done <= 1'b0;
            pend       <= pend || hblank_req;
            case (state)
                INIT: state <= LOAD;
                WAIT_FRAME: begin
                    if (pend || hblank_req) begin
                        state <= LATCH;
                        lcnt  <= LATCH_LOAD;
                        pend  <= 1'b0;
                        busy  <= 1'b1;
                    end else if (enable && bus.fifo_level >= FRAME_LVL) begin
                        state <= FETCH;
                        rd_en <= 1'b1;
                        rcnt  <= 2'd0;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    rcnt <= rcnt + 2'd1;
                    if (rcnt == 2'd2) begin
                        rd_en <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (fire) begin
                        wr <= N_STRINGS'(1) << s;
                        s  <= s == LAST_S ? '0 : s + 1'b1;
                        if (s == LAST_S)
                            p <= p == LAST_P ? '0 : p + 1'b1;
                        if (s == LAST_S && p == LAST_P)
                            state <= DRAIN;
                        else if (init_run)
                            state <= INIT;
                        else begin
                            state <= FETCH;
                            rd_en <= 1'b1;
                            rcnt  <= 2'd0;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.ser_busy == '0 && wr == '0) begin
                        state <= LATCH;
                        lcnt  <= LATCH_LOAD;
                        fr    <= 1'b1;
                    end
                end
                LATCH: begin
                    if (lcnt != '0)
                        lcnt <= lcnt - 1'b1;
                    else if (pend || hblank_req) begin
                        lcnt <= LATCH_LOAD;
                        pend <= 1'b0;
                    end else begin
                        state      <= WAIT_FRAME;
                        busy       <= 1'b0;
                        frame_done <= fr;
                        fr         <= 1'b0;
                        init_run   <= 1'b0;
                    end
                end
                default: state <= RST_STATE;
            endcase
        end
    end

    // frame-level gating must make an empty-FIFO pop impossible
    assert property (@(posedge clk) disable iff (rst) bus.fifo_rd_en |-> bus.fifo_level != '0);
endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb_led_frame_sequencer: randomized frames against a FIFO/serializer model and a per-load scoreboard
module tb_led_frame_sequencer;
    import led_pkg::*;

    localparam int N   = 5;
    localparam int L   = 4;
    localparam int LAT = 300;
    localparam int LW  = 12;
    localparam int FB  = frame_bytes(N, L);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic hblank_req = 1'b0;
    logic frame_done;
    logic busy;

    led_frame_sequencer_if #(.N_STRINGS(N), .LEVEL_W(LW)) bus ();

    led_frame_sequencer #(
        .N_STRINGS(N), .N_LEDS_PER_STRING(L), .LATCH_CYCLES(LAT),
        .INIT_BYTE(8'h08), .LEVEL_W(LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .hblank_req (hblank_req),
        .bus        (bus),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int loads = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;
    int fd_gap = 0;
    int last_act = 0;
    int rel_cyc = 0;
    logic [7:0]  q[$];
    logic [7:0]  stg[$];
    logic [28:0] exp_q[$];
    logic [28:0] ld_val[$];
    int          ld_cyc[$];
    int          pop_idle[$];
    logic [7:0]  held = 8'h00;
    logic        prev_rd = 1'b0;
    logic [N-1:0] hold = '0;
    int          bcnt[N];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // FIFO, serializer and load/frame_done monitor, all sampled mid-cycle
    always @(negedge clk) begin
        logic [N-1:0] nb;
        if (bus.pix_wr != '0) begin
            ld_cyc.push_back(cyc);
            ld_val.push_back({bus.pix_wr, bus.pix_data});
            loads++;
            chk("ser_idle", 32'(bus.pix_wr & bus.ser_busy), 0);
            if (exp_q.size() == 0) chk("extra_load", 32'(bus.pix_wr), 0);
            else chk("load", 32'({bus.pix_wr, bus.pix_data}), 32'(exp_q.pop_front()));
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
            fd_gap = cyc - last_act;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.pix_wr[i]) bcnt[i] = $urandom_range(40, 5);
            else if (bcnt[i] > 0) bcnt[i]--;
            nb[i] = bcnt[i] > 0 || hold[i];
        end
        if (bus.ser_busy[2] && !nb[2]) rel_cyc = cyc;
        bus.ser_busy = nb;
        if (nb != '0 || bus.pix_wr != '0) last_act = cyc;
        if (prev_rd) bus.fifo_rd_data = held;
        bus.fifo_level = LW'(q.size());
        if (bus.fifo_rd_en) begin
            if (q.size() == 0) chk("pop_empty", 32'(q.size()), 1);
            else held = q.pop_front();
            pop_idle.push_back(cyc - last_act);
            pops++;
        end
        prev_rd = bus.fifo_rd_en;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_frame(input bit ramp);
        logic [7:0] b[FB];
        for (int i = 0; i < FB; i++) b[i] = ramp ? 8'(i) : 8'($urandom);
        for (int i = 0; i < FB; i++) stg.push_back(b[i]);
        for (int j = 0; j < FB / 3; j++)
            exp_q.push_back({N'(1 << (j % N)), b[3*j+2], b[3*j+1], b[3*j]});
    endtask

    task automatic push_init();
        for (int j = 0; j < FB / 3; j++) exp_q.push_back({N'(1 << (j % N)), 24'h080808});
    endtask

    task automatic move(input int n);
        repeat (n) q.push_back(stg.pop_front());
    endtask

    task automatic wait_fd(input int target, input int budget);
        int n = 0;
        while (fd_cnt < target && n < budget) begin @(negedge clk); n++; end
        if (fd_cnt < target) chk("fd_timeout", fd_cnt, target);
        tick(1);
    endtask

    task automatic wait_loads(input int target, input int budget);
        int n = 0;
        while (loads < target && n < budget) begin @(negedge clk); n++; end
        if (loads < target) chk("load_timeout", loads, target);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (pops < target && n < budget) begin @(negedge clk); n++; end
        if (pops < target) chk("pop_timeout", pops, target);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bld, bfd, r0, p0;
        bus.fifo_level = '0;
        bus.fifo_rd_data = '0;
        bus.ser_busy = '0;
        for (int i = 0; i < N; i++) bcnt[i] = 0;
`ifdef LED_INIT_FRAME_EN
        push_init();
`endif
        tick(4);
        chk("rst_busy", busy, 1);
        chk("rst_rd", bus.fifo_rd_en, 0);
        chk("rst_wr", 32'(bus.pix_wr), 0);
        chk("rst_pix", bus.pix_data, 0);
        chk("rst_fd", frame_done, 0);
        rst = 1'b0;
        r0 = cyc;
        wait_fd(1, 3000);
`ifdef LED_INIT_FRAME_EN
        chk("init_loads", loads, FB / 3);
        chk("init_gap", fd_gap >= LAT && fd_gap <= LAT + 4, 1);
`else
        chk("boot_loads", loads, 0);
        chk("boot_gap", (fd_cyc - r0) >= LAT && (fd_cyc - r0) <= LAT + 4, 1);
`endif
        chk("init_pops", pops, 0);
        chk("init_left", exp_q.size(), 0);
        chk("idle_busy", busy, 0);

        enable = 1'b1;
        base = pops;
        bfd = fd_cnt;
        push_frame(0);
        move(FB - 1);
        tick(1000);
        chk("partial_pops", pops - base, 0);
        move(1);
        wait_fd(bfd + 1, 3000);
        chk("frame_pops", pops - base, FB);
        chk("frame_left", exp_q.size(), 0);

        base = pops;
        bld = loads;
        bfd = fd_cnt;
        push_frame(1);
        move(FB);
        wait_fd(bfd + 1, 3000);
        chk("ramp_first", ld_val[bld], {5'b00001, 24'h020100});
        chk("ramp_sixth", ld_val[bld+5], {5'b00001, 24'h11100F});
        chk("ramp_pops", pops - base, FB);

        base = pops;
        bld = loads;
        bfd = fd_cnt;
        hold[2] = 1'b1;
        push_frame(0);
        move(FB);
        wait_loads(bld + 2, 2000);
        tick(20);
        p0 = pops;
        tick(480);
        chk("stall_pops", pops - p0, 0);
        chk("stall_fetched", pops - base, 9);
        chk("stall_loads", loads - bld, 2);
        hold[2] = 1'b0;
        wait_loads(bld + 3, 50);
        chk("release_lat", ld_cyc[bld+2] - rel_cyc, 1);
        wait_fd(bfd + 1, 3000);
        chk("stall_total", pops - base, FB);
        chk("stall_left", exp_q.size(), 0);

        for (int f = 0; f < 2; f++) begin
            base = pops;
            bfd = fd_cnt;
            push_frame(0);
            move(FB);
            wait_pops(base + 1, 100);
            enable = 1'b0;
            wait_fd(bfd + 1, 3000);
            chk("noen_pops", pops - base, FB);
            chk("noen_left", exp_q.size(), 0);
            tick(50);
            enable = 1'b1;
        end

        base = pops;
        bld = loads;
        bfd = fd_cnt;
        push_frame(0);
        push_frame(0);
        move(2 * FB);
        wait_loads(bld + FB / 3, 2000);
        tick(60);
        hblank_req = 1'b1;
        tick(1);
        hblank_req = 1'b0;
        wait_fd(bfd + 2, 6000);
        tick(20);
        chk("hb_gap", pop_idle[base+FB] >= 2 * LAT, 1);
        chk("hb_fd", fd_cnt - bfd, 2);
        chk("hb_pops", pops - base, 2 * FB);
        chk("hb_left", exp_q.size(), 0);

        base = pops;
        push_frame(0);
        move(FB);
        wait_pops(base + 5, 2000);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rd", bus.fifo_rd_en, 0);
        chk("rst_mid_busy", busy, 1);
        #2;
        q.delete();
        stg.delete();
        exp_q.delete();
`ifdef LED_INIT_FRAME_EN
        push_init();
`endif
        tick(3);
        base = pops;
        bld = loads;
        bfd = fd_cnt;
        rst = 1'b0;
        wait_fd(bfd + 1, 3000);
        chk("restart_pops", pops - base, 0);
`ifdef LED_INIT_FRAME_EN
        chk("restart_loads", loads - bld, FB / 3);
`else
        chk("restart_loads", loads - bld, 0);
`endif
        chk("restart_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
